// File: rtl/imem_boot_loader.sv
// Boot-time instruction store: streams 32-bit words in over valid/ready, holds the
// core in reset until the image is complete, and serves combinational fetch.
module imem_boot_loader #(
  parameter int DEPTH_WORDS    = 64,
  parameter int ADDR_W         = 32,
  parameter bit BIG_ENDIAN_IN  = 1'b0,
  parameter int RELEASE_CYCLES = 2,
  parameter int CW             = $clog2(DEPTH_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              core_rst_n,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       fetch_instr,
  output logic              done,
  output logic              overflow,
  output logic [CW-1:0]     word_count
);

  localparam int          IW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          RW  = $clog2(RELEASE_CYCLES + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RELEASE, S_RUN, S_ERROR} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [RW-1:0]   relCnt_q, relCnt_d;
  logic            ovf_q, ovf_d;
  logic            ready_q, coreRstN_q, done_q;
  logic            wrEn;
  logic [7:0]      mem_q [DEPTH_WORDS][4];
  logic [IW-1:0]   wrIdx;
  logic [ADDR_W-1:0] fetchWord;
  logic [IW-1:0]   fetchIdx;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    relCnt_d = relCnt_q;
    ovf_d    = ovf_q;
    wrEn     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end
      S_LOAD: begin
        // A restart wins over a beat presented on the same cycle.
        if (start) begin
          count_d = '0;
        end else if (load_valid && ready_q) begin
          if (count_q < CW'(DEPTH_WORDS)) begin
            wrEn    = 1'b1;
            count_d = count_q + CW'(1);
            if (load_last) begin
              state_d  = S_RELEASE;
              relCnt_d = '0;
            end
          end else begin
            ovf_d   = 1'b1;
            state_d = S_ERROR;
          end
        end
      end
      S_RELEASE: begin
        if (relCnt_q == RW'(RELEASE_CYCLES)) state_d = S_RUN;
        else relCnt_d = relCnt_q + RW'(1);
      end
      S_RUN, S_ERROR: begin
        if (start) begin
          state_d = S_LOAD;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and core-control outputs are registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      relCnt_q   <= '0;
      ovf_q      <= 1'b0;
      ready_q    <= 1'b0;
      coreRstN_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      relCnt_q   <= relCnt_d;
      ovf_q      <= ovf_d;
      ready_q    <= (state_d == S_LOAD);
      coreRstN_q <= (state_d == S_RUN);
      done_q     <= (state_d == S_RUN);
    end
  end

  assign wrIdx = count_q[IW-1:0];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int b = 0; b < 4; b++) begin
        mem_q[wrIdx][b] <= BIG_ENDIAN_IN ? load_data[8*(3-b) +: 8] : load_data[8*b +: 8];
      end
    end
  end

  assign fetchWord = fetch_addr >> 2;
  assign fetchIdx  = fetchWord[IW-1:0];

  always_comb begin
    fetch_instr = NOP;
    if (fetchWord < ADDR_W'(DEPTH_WORDS)) begin
      fetch_instr = {mem_q[fetchIdx][3], mem_q[fetchIdx][2], mem_q[fetchIdx][1], mem_q[fetchIdx][0]};
    end
  end

  assign load_ready = ready_q;
  assign core_rst_n = coreRstN_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Drives two loader instances (8-word little-endian, 4-word big-endian) with shared
// stimulus and compares both against a word-level model plus hand-written vectors.
module tb_imem_boot_loader;

  localparam int DA = 8;
  localparam int DB = 4;
  localparam int RC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_last = 1'b0;
  logic [31:0] load_data = '0;
  logic [31:0] fetch_addr = '0;

  logic        readyA, crnA, doneA, ovfA;
  logic [3:0]  wcA;
  logic [31:0] fetchA;
  logic        readyB, crnB, doneB, ovfB;
  logic [2:0]  wcB;
  logic [31:0] fetchB;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imem_boot_loader #(.DEPTH_WORDS(DA), .ADDR_W(32), .BIG_ENDIAN_IN(1'b0), .RELEASE_CYCLES(RC)) u_a (
    .clk(clk), .rst(rst), .start(start), .load_valid(load_valid), .load_ready(readyA),
    .load_data(load_data), .load_last(load_last), .core_rst_n(crnA), .fetch_addr(fetch_addr),
    .fetch_instr(fetchA), .done(doneA), .overflow(ovfA), .word_count(wcA));

  imem_boot_loader #(.DEPTH_WORDS(DB), .ADDR_W(32), .BIG_ENDIAN_IN(1'b1), .RELEASE_CYCLES(RC)) u_b (
    .clk(clk), .rst(rst), .start(start), .load_valid(load_valid), .load_ready(readyB),
    .load_data(load_data), .load_last(load_last), .core_rst_n(crnB), .fetch_addr(fetch_addr),
    .fetch_instr(fetchB), .done(doneB), .overflow(ovfB), .word_count(wcB));

  // Word-level reference: a mode per instance, a release countdown and a word store.
  typedef enum int {M_IDLE, M_LOAD, M_REL, M_RUN, M_ERR} mode_t;
  mode_t       mMode [2];
  int          mCount [2];
  bit          mOvf [2];
  int          mRelLeft [2];
  logic [31:0] mMem [2][8];
  bit          mKnown [2][8];
  int          depth [2] = '{DA, DB};
  bit          bigEnd [2] = '{1'b0, 1'b1};

  typedef struct {
    bit          st;
    bit          v;
    logic [31:0] d;
    bit          l;
    int          wc;
    bit          rdy;
    bit          crn;
    bit          dn;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] expA;
  } fvec_t;

  vec_t  leTab [8];
  fvec_t fTab [6];

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mMode[k]    = M_IDLE;
      mCount[k]   = 0;
      mOvf[k]     = 1'b0;
      mRelLeft[k] = 0;
    end
  endtask

  task automatic modelStep();
    if (!rst) return;
    for (int k = 0; k < 2; k++) begin
      case (mMode[k])
        M_IDLE: if (start) begin mMode[k] = M_LOAD; mCount[k] = 0; end
        M_LOAD: begin
          if (start) mCount[k] = 0;
          else if (load_valid) begin
            if (mCount[k] < depth[k]) begin
              mMem[k][mCount[k]]   = bigEnd[k] ? bswap(load_data) : load_data;
              mKnown[k][mCount[k]] = 1'b1;
              mCount[k]++;
              if (load_last) begin mMode[k] = M_REL; mRelLeft[k] = RC + 1; end
            end else begin
              mOvf[k]  = 1'b1;
              mMode[k] = M_ERR;
            end
          end
        end
        M_REL: begin
          mRelLeft[k]--;
          if (mRelLeft[k] == 0) mMode[k] = M_RUN;
        end
        default: if (start) begin mMode[k] = M_LOAD; mCount[k] = 0; mOvf[k] = 1'b0; end
      endcase
    end
  endtask

  task automatic checkModel();
    logic [31:0] idx;
    idx = fetch_addr >> 2;
    for (int k = 0; k < 2; k++) begin
      string nm = (k == 0) ? "A" : "B";
      checkOutput({nm, ".ready"}, (k == 0) ? 32'(readyA) : 32'(readyB), 32'(mMode[k] == M_LOAD));
      checkOutput({nm, ".core_rst_n"}, (k == 0) ? 32'(crnA) : 32'(crnB), 32'(mMode[k] == M_RUN));
      checkOutput({nm, ".done"}, (k == 0) ? 32'(doneA) : 32'(doneB), 32'(mMode[k] == M_RUN));
      checkOutput({nm, ".overflow"}, (k == 0) ? 32'(ovfA) : 32'(ovfB), 32'(mOvf[k]));
      checkOutput({nm, ".word_count"}, (k == 0) ? 32'(wcA) : 32'(wcB), mCount[k]);
      if (idx >= 32'(depth[k]))
        checkOutput({nm, ".fetch_oor"}, (k == 0) ? fetchA : fetchB, 32'h0000_0013);
      else if (mKnown[k][idx])
        checkOutput({nm, ".fetch"}, (k == 0) ? fetchA : fetchB, mMem[k][idx]);
    end
  endtask

  task automatic applyStimulus(input bit st, input bit v, input logic [31:0] d, input bit l);
    start      = st;
    load_valid = v;
    load_data  = d;
    load_last  = l;
    modelStep();
    @(posedge clk);
    #1;
    checkModel();
  endtask

  task automatic doReset();
    rst = 1'b0;
    #1;
    modelReset();
    checkModel();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    leTab[0] = '{1'b1, 1'b0, 32'h0,         1'b0, 0, 1'b1, 1'b0, 1'b0};
    leTab[1] = '{1'b0, 1'b1, 32'h00500093, 1'b0, 1, 1'b1, 1'b0, 1'b0};
    leTab[2] = '{1'b0, 1'b1, 32'h00A00113, 1'b0, 2, 1'b1, 1'b0, 1'b0};
    leTab[3] = '{1'b0, 1'b1, 32'h002081B3, 1'b0, 3, 1'b1, 1'b0, 1'b0};
    leTab[4] = '{1'b0, 1'b1, 32'h0000006F, 1'b1, 4, 1'b0, 1'b0, 1'b0};
    leTab[5] = '{1'b0, 1'b0, 32'h0,         1'b0, 4, 1'b0, 1'b0, 1'b0};
    leTab[6] = '{1'b0, 1'b0, 32'h0,         1'b0, 4, 1'b0, 1'b0, 1'b0};
    leTab[7] = '{1'b0, 1'b0, 32'h0,         1'b0, 4, 1'b0, 1'b1, 1'b1};

    fTab[0] = '{32'd32, 32'h0000_0013};
    fTab[1] = '{32'd5,  32'h2000_0001};
    fTab[2] = '{32'd0,  32'h2000_0000};
    fTab[3] = '{32'd8,  32'h1000_0002};
    fTab[4] = '{32'd23, 32'h1000_0005};
    fTab[5] = '{32'd36, 32'h0000_0013};

    // Power-on reset.
    #2;
    modelReset();
    checkModel();
    checkOutput("rst.ready", 32'(readyA), 0);
    checkOutput("rst.core_rst_n", 32'(crnA), 0);
    checkOutput("rst.done", 32'(doneA), 0);
    checkOutput("rst.overflow", 32'(ovfA), 0);
    checkOutput("rst.word_count", 32'(wcA), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Little-endian four-word image.
    fetch_addr = 32'h8;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(leTab[i].st, leTab[i].v, leTab[i].d, leTab[i].l);
      checkOutput($sformatf("le[%0d].word_count", i), 32'(wcA), leTab[i].wc);
      checkOutput($sformatf("le[%0d].ready", i), 32'(readyA), 32'(leTab[i].rdy));
      checkOutput($sformatf("le[%0d].core_rst_n", i), 32'(crnA), 32'(leTab[i].crn));
      checkOutput($sformatf("le[%0d].done", i), 32'(doneA), 32'(leTab[i].dn));
    end
    checkOutput("le.fetch8", fetchA, 32'h002081B3);

    // Big-endian single-beat image.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h13000000, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    fetch_addr = 32'h0;
    #1;
    checkOutput("be.fetch0", fetchB, 32'h0000_0013);
    checkOutput("be.fetch0_le", fetchA, 32'h1300_0000);
    checkOutput("be.done", 32'(doneB), 1);

    // Overflow on the four-word instance.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 32'hA000_00A0 + i, 1'b0);
    checkOutput("ovf.full_count", 32'(wcB), 4);
    checkOutput("ovf.full_flag", 32'(ovfB), 0);
    applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("ovf.flag", 32'(ovfB), 1);
    checkOutput("ovf.core_rst_n", 32'(crnB), 0);
    checkOutput("ovf.ready", 32'(readyB), 0);
    checkOutput("ovf.word_count", 32'(wcB), 4);
    for (int i = 0; i < 4; i++) begin
      fetch_addr = 32'(4 * i);
      #1;
      checkOutput($sformatf("ovf.fetch%0d", i), fetchB, bswap(32'hA000_00A0 + 32'(i)));
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("ovf.clear_flag", 32'(ovfB), 0);
    checkOutput("ovf.clear_count", 32'(wcB), 0);

    // Backpressure: valid every other cycle across six words.
    for (int i = 0; i < 12; i++) begin
      bit v;
      v = (i % 2) == 0;
      applyStimulus(1'b0, v, 32'h1000_0000 + 32'(i / 2), (i == 10));
      checkOutput($sformatf("bp[%0d].word_count", i), 32'(wcA), (i / 2) + 1);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("bp.done", 32'(doneA), 1);
    for (int i = 0; i < 6; i++) begin
      fetch_addr = 32'(4 * i);
      #1;
      checkOutput($sformatf("bp.fetch%0d", i), fetchA, 32'h1000_0000 + 32'(i));
    end

    // Reload from RUN, then abort with reset mid-load.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("reload.done", 32'(doneA), 0);
    checkOutput("reload.core_rst_n", 32'(crnA), 0);
    checkOutput("reload.word_count", 32'(wcA), 0);
    applyStimulus(1'b0, 1'b1, 32'h2000_0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h2000_0001, 1'b0);
    load_valid = 1'b0;
    doReset();
    checkOutput("abort.word_count", 32'(wcA), 0);
    checkOutput("abort.ready", 32'(readyA), 0);

    for (int i = 0; i < 6; i++) begin
      fetch_addr = fTab[i].addr;
      #1;
      checkOutput($sformatf("ftab[%0d]", i), fetchA, fTab[i].expA);
    end
    fetch_addr = 32'd16;
    #1;
    checkOutput("oor.B", fetchB, 32'h0000_0013);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      bit st;
      st = (mMode[0] != M_REL) && (mMode[1] != M_REL) && ($urandom_range(0, 19) == 0);
      fetch_addr = 32'($urandom_range(0, 63));
      applyStimulus(st, 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 149) == 0) doReset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
